// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the handshaked pipeline stage register:
// datapath width defaults, the bubble instruction and the control-word
// field layout used by every stage that carries a packed ctrl word.
package pipe_stage_reg_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int INST_LEN_DEF = 32;
    localparam int CTRL_W_DEF   = 12;
    localparam int CNT_W_DEF    = 32;

    // addi x0,x0,0 -- harmless instruction presented whenever a stage is empty
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // Control-word field offsets (LSB position and width)
    localparam int CTRL_ALUCTR_LSB = 0;
    localparam int CTRL_ALUCTR_W   = 4;
    localparam int CTRL_IS_JAL     = 4;
    localparam int CTRL_IS_JALR    = 5;
    localparam int CTRL_IS_BRC     = 6;
    localparam int CTRL_SRC1_LSB   = 7;
    localparam int CTRL_SRC1_W     = 2;
    localparam int CTRL_SRC2_LSB   = 9;
    localparam int CTRL_SRC2_W     = 2;
    localparam int CTRL_WBEN       = 11;

    // Width of the internal packed payload {pc, instr, rs1, rs2, imm, ctrl}
    function automatic int payload_w(input int xlen, input int inst_len, input int ctrl_w);
        return 4 * xlen + inst_len + ctrl_w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] cnt_q;

    // Increment on request unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register carrying pc/instr/rs1/rs2/imm/ctrl.
// Optional build macro PIPE_STAGE_SKID_EN adds a one-entry skid buffer so
// in_ready comes straight from a flop instead of from out_ready.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid and ready are both 1. valid never depends on ready; once
// out_valid is raised the payload is held bit-stable until out_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                  XLEN     = XLEN_DEF,
    parameter int                  INST_LEN = INST_LEN_DEF,
    parameter int                  CTRL_W   = CTRL_W_DEF,
    parameter logic [INST_LEN-1:0] NOP_INST = INST_LEN'(NOP_INST_DEF),
    parameter int                  CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [INST_LEN-1:0] instr_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic [XLEN-1:0]     imm_i,
    input  logic [CTRL_W-1:0]   ctrl_i,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     pc_o,
    output logic [INST_LEN-1:0] instr_o,
    output logic [XLEN-1:0]     rs1_o,
    output logic [XLEN-1:0]     rs2_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam int PW       = payload_w(XLEN, INST_LEN, CTRL_W);
    localparam int INST_LSB = 3 * XLEN + CTRL_W;

    localparam logic [PW-1:0] RESET_PAYLOAD =
        {{XLEN{1'b0}}, NOP_INST, {(3 * XLEN + CTRL_W){1'b0}}};

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_q, out_d;
    logic          ready_q, ready_d;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] bubble;
    logic          in_xfer, out_xfer;
    logic          held_any;

    assign in_payload = {pc_i, instr_i, rs1_i, rs2_i, imm_i, ctrl_i};
    assign {pc_o, instr_o, rs1_o, rs2_o, imm_o, ctrl_o} = out_q;
    assign out_valid  = out_valid_q;
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid_q & out_ready;

    // Bubble keeps pc/rs/imm but neutralises instruction and control
    always_comb begin
        bubble                          = out_q;
        bubble[INST_LSB +: INST_LEN]    = NOP_INST;
        bubble[CTRL_W-1:0]              = '0;
    end

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] skid_q, skid_d;

    // in_ready is registered: it only reflects whether the skid slot is free
    assign in_ready = ready_q;
    assign held_any = out_valid_q | skid_valid_q;

    // Next state: flush wins, then skid drains before new input, else stall into skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_d        = bubble;
            skid_valid_d = 1'b0;
        end else if (out_xfer || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_d       = in_payload;
            end else begin
                out_valid_d = 1'b0;
                out_d       = bubble;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_d       = in_payload;
        end
        ready_d = ~skid_valid_d;
    end

    // Skid entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    // Ready whenever the output slot is free or being drained this cycle
    assign in_ready = ready_q & (~out_valid_q | out_ready);
    assign held_any = out_valid_q;

    // Next state: flush wins, then load a new beat, else bubble once empty
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ready_d     = 1'b1;
        if (flush) begin
            out_valid_d = 1'b0;
            out_d       = bubble;
        end else if (in_xfer) begin
            out_valid_d = 1'b1;
            out_d       = in_payload;
        end else if (out_xfer || !out_valid_q) begin
            out_valid_d = 1'b0;
            out_d       = bubble;
        end
    end
`endif

    // Output register; ready_q holds in_ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= RESET_PAYLOAD;
            ready_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ready_q     <= ready_d;
        end
    end

    // A stalled cycle is a presented beat the consumer did not take
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~out_ready),
        .value (stall_cnt)
    );

    // Flushes count only when a held beat is thrown away
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush & held_any),
        .value (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// traffic, all compared against an in-order queue model of held beats.
module tb_pipe_stage_reg;

    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;
    localparam int CTRL_W   = 12;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [11:0] ctrl;
    } beat_t;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     pc_i, rs1_i, rs2_i, imm_i;
    logic [INST_LEN-1:0] instr_i;
    logic [CTRL_W-1:0]   ctrl_i;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     pc_o, rs1_o, rs2_o, imm_o;
    logic [INST_LEN-1:0] instr_o;
    logic [CTRL_W-1:0]   ctrl_o;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    beat_t last_shown;
    int    exp_stall;
    int    exp_flush;

    pipe_stage_reg #(
        .XLEN(XLEN), .INST_LEN(INST_LEN), .CTRL_W(CTRL_W),
        .NOP_INST(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .imm_i(imm_i), .ctrl_i(ctrl_i), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .instr_o(instr_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .imm_o(imm_o), .ctrl_o(ctrl_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.pc    = {$urandom, $urandom};
        b.instr = $urandom;
        b.rs1   = {$urandom, $urandom};
        b.rs2   = {$urandom, $urandom};
        b.imm   = {$urandom, $urandom};
        b.ctrl  = 12'($urandom);
        return b;
    endfunction

    // Stage may take a beat if it has room, or (no skid) the head leaves now
    function automatic logic model_ready(input logic ordy);
        if (DEPTH == 2) return exp_q.size() < 2;
        return (exp_q.size() == 0) || ordy;
    endfunction

    // Compare all DUT outputs with the model's view of the stage
    task automatic check_outputs(input logic ordy);
        beat_t cur;
        check_eq("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            cur        = exp_q[0];
            last_shown = cur;
            check_eq("pc_o", pc_o, cur.pc);
            check_eq("instr_o", instr_o, cur.instr);
            check_eq("rs1_o", rs1_o, cur.rs1);
            check_eq("rs2_o", rs2_o, cur.rs2);
            check_eq("imm_o", imm_o, cur.imm);
            check_eq("ctrl_o", ctrl_o, cur.ctrl);
        end else begin
            check_eq("bubble_ctrl", ctrl_o, 0);
            check_eq("bubble_instr", instr_o, NOP);
            check_eq("bubble_pc", pc_o, last_shown.pc);
            check_eq("bubble_rs1", rs1_o, last_shown.rs1);
            check_eq("bubble_rs2", rs2_o, last_shown.rs2);
            check_eq("bubble_imm", imm_o, last_shown.imm);
        end
        check_eq("in_ready", in_ready, model_ready(ordy));
        check_eq("stall_cnt", stall_cnt, exp_stall);
        check_eq("flush_cnt", flush_cnt, exp_flush);
    endtask

    // Advance the model across one edge
    task automatic model_step(input logic iv, input logic ordy, input logic fl, input beat_t b);
        logic in_x, out_x;
        in_x  = iv && model_ready(ordy);
        out_x = (exp_q.size() > 0) && ordy;
        if ((exp_q.size() > 0) && !ordy && (exp_stall < CNT_MAX)) exp_stall++;
        if (fl) begin
            if ((exp_q.size() > 0) && (exp_flush < CNT_MAX)) exp_flush++;
            exp_q.delete();
        end else begin
            if (out_x) void'(exp_q.pop_front());
            if (in_x) exp_q.push_back(b);
        end
    endtask

    // Drive one cycle, check, step the model; acc reports a DUT-side accept
    task automatic do_cycle(input logic iv, input logic ordy, input logic fl,
                            input beat_t b, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        pc_i      = b.pc;
        instr_i   = b.instr;
        rs1_i     = b.rs1;
        rs2_i     = b.rs2;
        imm_i     = b.imm;
        ctrl_i    = b.ctrl;
        #1;
        acc = in_valid & in_ready;
        check_outputs(ordy);
        model_step(iv, ordy, fl, b);
    endtask

    // Asynchronous reset asserted between edges, checked immediately
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_ctrl", ctrl_o, 0);
        check_eq("rst_instr", instr_o, NOP);
        check_eq("rst_pc", pc_o, 0);
        check_eq("rst_imm", imm_o, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst_flush_cnt", flush_cnt, 0);
        check_eq("rst_in_ready", in_ready, 0);
        exp_q.delete();
        last_shown = '0;
        exp_stall  = 0;
        exp_flush  = 0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        beat_t b;
        logic  acc;
        int    n_acc;
        logic  iv, ordy, fl;
        int    pv, pr;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        pc_i = '0; instr_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0; ctrl_i = '0;
        apply_reset();

        // Streaming: 8 sequential PCs with the consumer always ready
        for (int k = 0; k < 8; k++) begin
            b    = rand_beat();
            b.pc = 64'h8000_0000 + 64'(4 * k);
            do_cycle(1'b1, 1'b1, 1'b0, b, acc);
        end
        do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);
        do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);
        check_eq("stream_stall_cnt", stall_cnt, 0);

        // Backpressure: hold one beat for 5 cycles while upstream keeps offering
        do_cycle(1'b1, 1'b1, 1'b0, rand_beat(), acc);
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            do_cycle(1'b1, 1'b0, 1'b0, rand_beat(), acc);
            n_acc += int'(acc);
        end
        check_eq("bp_extra_accepts", n_acc, DEPTH - 1);
        do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);
        check_eq("bp_stall_cnt", stall_cnt, 5);
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);

        // Flush of a full stage with a same-cycle input, then flush on empty
        apply_reset();
        do_cycle(1'b1, 1'b0, 1'b0, rand_beat(), acc);
        do_cycle(1'b1, 1'b0, 1'b0, rand_beat(), acc);
        do_cycle(1'b1, 1'b1, 1'b1, rand_beat(), acc);
        do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_instr", instr_o, NOP);
        check_eq("flush_cnt_one", flush_cnt, 1);
        do_cycle(1'b0, 1'b1, 1'b1, rand_beat(), acc);
        do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);
        check_eq("flush_empty_cnt", flush_cnt, 1);

        // Saturation: a long stall must pin stall_cnt at all-ones
        do_cycle(1'b1, 1'b1, 1'b0, rand_beat(), acc);
        for (int k = 0; k < 20; k++) do_cycle(1'b0, 1'b0, 1'b0, rand_beat(), acc);
        do_cycle(1'b0, 1'b1, 1'b0, rand_beat(), acc);
        check_eq("stall_sat", stall_cnt, CNT_MAX);

        // Randomized phases, each ended by an asynchronous mid-stream reset
        for (int p = 0; p < 25; p++) begin
            pv = $urandom_range(1, 4);
            pr = $urandom_range(1, 4);
            for (int c = 0; c < 30; c++) begin
                iv   = ($urandom_range(0, 4) < pv);
                ordy = ($urandom_range(0, 4) < pr);
                fl   = ($urandom_range(0, 15) == 0);
                do_cycle(iv, ordy, fl, rand_beat(), acc);
            end
            apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
